// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM demultiplexer and its slot counter.
package tdm_pkg;

    localparam int unsigned DEF_N_CH = 4;
    localparam int unsigned DEF_W    = 8;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Bits needed to hold values 0..n-1 (at least one bit)
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((32'd1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Modulo-N_CH slot counter; load_one restarts a frame at slot 1 and wins over inc.
module tdm_slot_counter
    import tdm_pkg::*;
#(
    parameter int unsigned N_CH = DEF_N_CH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     inc,
    input  logic                     load_one,
    output logic [clog2(N_CH)-1:0]   slot
);

    localparam int unsigned SW = clog2(N_CH);

    // Slot register: reload, advance with wrap, or hold
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot <= '0;
        end else if (load_one) begin
            slot <= SW'(1);
        end else if (inc) begin
            slot <= (slot == SW'(N_CH - 1)) ? '0 : slot + SW'(1);
        end
    end

endmodule

// File: rtl/tdm_demux.sv
// TDM receive demultiplexer: steers interleaved words to per-channel registers,
// aligned by a frame-sync marker on slot 0.
// Optional macro TDM_DEMUX_STATS_EN adds frame_cnt / err_cnt statistics outputs.
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int unsigned N_CH = DEF_N_CH,
    parameter int unsigned W    = DEF_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [W-1:0]        din,
    input  logic                din_valid,
    input  logic                frame_sync,
    output logic [N_CH*W-1:0]   ch_data,
    output logic [N_CH-1:0]     ch_valid,
    output logic                frame_done,
    output logic                locked,
    output logic                sync_err
`ifdef TDM_DEMUX_STATS_EN
   ,output logic [15:0]         frame_cnt,
    output logic [7:0]          err_cnt
`endif
);

    localparam int unsigned SW = clog2(N_CH);

    state_t          state;
    state_t          state_nxt_c;
    logic [SW-1:0]   slot;
    logic            inc_c;
    logic            load_one_c;
    logic            wr_en_c;
    logic [SW-1:0]   wr_idx_c;
    logic            err_c;
    logic            fd_c;

    tdm_slot_counter #(
        .N_CH (N_CH)
    ) u_slot_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (inc_c),
        .load_one (load_one_c),
        .slot     (slot)
    );

    // Classify the accepted word against the current state and slot
    always_comb begin
        state_nxt_c = state;
        inc_c       = 1'b0;
        load_one_c  = 1'b0;
        wr_en_c     = 1'b0;
        wr_idx_c    = '0;
        err_c       = 1'b0;
        fd_c        = 1'b0;
        if (din_valid) begin
            if (state == HUNT) begin
                if (frame_sync) begin
                    wr_en_c     = 1'b1;
                    load_one_c  = 1'b1;
                    state_nxt_c = LOCKED;
                end
            end else begin
                if (frame_sync) begin
                    // Sync always realigns to slot 0; early sync is flagged
                    wr_en_c    = 1'b1;
                    load_one_c = 1'b1;
                    err_c      = (slot != '0);
                end else if (slot == '0) begin
                    // Missing sync: drop the word and go back to hunting
                    err_c       = 1'b1;
                    state_nxt_c = HUNT;
                end else begin
                    wr_en_c  = 1'b1;
                    wr_idx_c = slot;
                    inc_c    = 1'b1;
                    fd_c     = (slot == SW'(N_CH - 1));
                end
            end
        end
    end

    // State, channel registers, pulses and statistics
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= HUNT;
            ch_data    <= '0;
            ch_valid   <= '0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
            locked     <= 1'b0;
`ifdef TDM_DEMUX_STATS_EN
            frame_cnt  <= '0;
            err_cnt    <= '0;
`endif
        end else begin
            state      <= state_nxt_c;
            locked     <= (state_nxt_c == LOCKED);
            frame_done <= fd_c;
            sync_err   <= err_c;
            ch_valid   <= '0;
            for (int unsigned k = 0; k < N_CH; k++) begin
                if (wr_en_c && (wr_idx_c == SW'(k))) begin
                    ch_data[k*W +: W] <= din;
                    ch_valid[k]       <= 1'b1;
                end
            end
`ifdef TDM_DEMUX_STATS_EN
            if (fd_c) frame_cnt <= frame_cnt + 16'd1;
            if (err_c && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
`endif
        end
    end

endmodule
